// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier.
//
// full_adder          : one-bit full-adder cell used to build the accumulator adder.
// seq_shift_add_mult  : WIDTH x WIDTH -> 2*WIDTH unsigned multiplier, one
//                       multiplier bit per cycle, fixed WIDTH-cycle run.
//
// Ports (seq_shift_add_mult):
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a/b valid this cycle
//   in_ready   out  block accepts operands (IDLE only)
//   a          in   WIDTH-bit unsigned multiplicand
//   b          in   WIDTH-bit unsigned multiplier
//   out_valid  out  product valid and held (DONE only)
//   out_ready  in   consumer takes the product this cycle
//   product    out  2*WIDTH-bit registered product
//   busy       out  high while the multiply is running (RUN only)

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    // One extra bit so the counter can still count the final RUN cycle.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic            accept_s;
    logic            last_s;

    logic [PW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [PW-1:0]    acc_r;
    logic [CW-1:0]    cnt_r;
    logic [PW-1:0]    product_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [PW-1:0]    addend_s;
    logic [PW-1:0]    sum_s;
    logic [PW-1:0]    carry_s;
    // Carry out of the MSB is dropped: a WIDTH x WIDTH product always fits.
    logic             unused_carry_out_s;

    // Addend gating: the multiplicand is added only when the multiplier LSB is set.
    always_comb begin
        addend_s = {PW{1'b0}};
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {PW{1'b0}};
        end
    end

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < PW; i++) begin : g_rca
        if (i == PW - 1) begin : g_msb
            full_adder u_fa (
                .a    (acc_r[i]),
                .b    (addend_s[i]),
                .cin  (carry_s[i]),
                .sum  (sum_s[i]),
                .cout (unused_carry_out_s)
            );
        end else begin : g_bit
            full_adder u_fa (
                .a    (acc_r[i]),
                .b    (addend_s[i]),
                .cin  (carry_s[i]),
                .sum  (sum_s[i]),
                .cout (carry_s[i+1])
            );
        end
    end

    // Next-state logic and per-cycle strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                // Fixed-length run: no early exit on zero operands.
                if (cnt_r == LAST_CNT) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: operand capture on accept, shift-and-add while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (accept_s) begin
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            acc_r    <= sum_s;
            mcand_r  <= {mcand_r[PW-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + CNT_ONE;
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
            cnt_r    <= cnt_r;
        end
    end

    // Product register: loaded with the final sum, kept after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_r <= {PW{1'b0}};
        end else if (last_s) begin
            product_r <= sum_s;
        end else begin
            product_r <= product_r;
        end
    end

    // Status flags registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s == RUN);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign product   = product_r;

endmodule
